pipe_unpack: RTL and testbench
==============================

# pipe_unpack

Width-down converter for the pipe datapath, performing the inverse of the pipeline's narrow-to-wide capture. It accepts IN_W-bit words on a valid/ready input. It emits each word as IN_W/OUT_W narrow beats, least-significant beat first, on a valid/ready output. A 2-entry input buffer decouples the producer from the serializer, so back-to-back words stream without bubbles.

## Interface

Parameters:
- IN_W, default 4: input word width. Must be an integer multiple of OUT_W, and IN_W/OUT_W must be at least 2.
- OUT_W, default 2: output beat width.

Ports:
- clk, input, 1: clock, all state on rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_data, input, IN_W: word to unpack.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: buffer can take a word. Transfer occurs when in_valid and in_ready are both high.
- out_data, output, OUT_W: current beat.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer takes the beat. Transfer occurs when out_valid and out_ready are both high.
- out_last, output, 1: current beat is the final beat of its word.
- busy, output, 1: buffer non-empty or serializer loaded.

## Operation

- RATIO = IN_W/OUT_W. The beat counter is $clog2(RATIO) bits wide.
- Input buffer:
  - 2-entry FIFO with pointer wrap-around.
  - in_ready = !full, registered.
  - A push is refused while full, even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full leaves the count unchanged.
- Serializer state machine, with two states:
  - IDLE: the shift register is empty.
    - If the buffer is non-empty: pop the head into the shift register, set beat=0, go to SHIFT.
  - SHIFT:
    - out_valid=1.
    - out_data = shift[OUT_W-1:0].
    - out_last = (beat==RATIO-1).
    - On an out transfer with beat<RATIO-1: shift right by OUT_W, beat+1.
    - On an out transfer with beat==RATIO-1 and the buffer non-empty: load the next head in the same edge, beat=0, stay in SHIFT (no bubble).
    - On an out transfer with beat==RATIO-1 and the buffer empty: go to IDLE.
- When out_ready is low, out_data and out_last hold stable, as does all serializer state.
- out_valid never deasserts without a transfer.
- Word order and beat order are preserved: FIFO order across words, LSB beat first within a word.
- Reset (asynchronous, takes effect immediately, including mid-word):
  - Buffer empties and in-flight data is discarded.
  - State goes to IDLE and beat=0.
  - out_data=0, out_valid=0, out_last=0, busy=0.
  - in_ready=1 once rst deasserts; it is held 0 while rst is high.

## Timing

- Latency: a word accepted at edge N enters the buffer at N. If IDLE, it loads at N+1, so out_valid is high after edge N+1 and the first beat is presented 2 cycles after acceptance.
- Throughput: 1 beat/cycle when out_ready is held high. Input sustains 1 word per RATIO cycles.
- in_ready falls in the cycle after the buffer reaches 2 entries. It rises in the cycle after a pop from a full buffer.
- busy is registered and follows buffer/shifter occupancy with 1 cycle lag.
- All outputs are registered; there is no combinational path from in_* or out_ready to any output.

## Structure

- Shared package pipe_pkg holds:
  - the serializer state enum (IDLE, SHIFT);
  - a function returning RATIO;
  - the parameter legality check (elaboration error if IN_W%OUT_W!=0 or RATIO<2).
- Sub-module pipe_skid_buf: a parameterised 2-entry FIFO with push/pop/full/empty. It is reusable by the pipe capture side.
- The top level contains the serializer and beat counter.

## Test plan

- Single word: push 4'hB with out_ready=1 -> out_data 2'b11 then 2'b10, with out_last=0 then 1. out_valid first rises 2 cycles after acceptance, and busy returns to 0.
- Streaming: push 4'h1, 4'h2, 4'h3 back-to-back with out_ready=1 -> beats 01,00,10,00,11,00 in consecutive cycles with no bubble, and out_last on every second beat.
- Backpressure: push 4'h6, 4'h9, 4'hC with out_ready=0 -> in_ready drops after two words are buffered and the third is held. out_data stays at 2'b10 throughout. On release, 10,01,01,10,00,11 are emitted.
- Refused push on full: buffer full, pop and in_valid in the same cycle -> the word is not accepted (in_ready=0). It is accepted the next cycle, and no data is lost or duplicated.
- Reset mid-word: assert rst after the first beat of 4'hE -> out_valid, out_data, out_last and busy are 0 immediately. After release, pushing 4'h5 yields 01,01 only, with no stale 11 beat.
- Parameter sweep: IN_W=8, OUT_W=2, push 8'hE4 -> beats 00,01,10,11, with out_last on the 4th beat.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe datapath: serializer states, width ratio
// and parameter legality helpers.
package pipe_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_e;

  function automatic int unsigned unpack_ratio(input int unsigned in_w,
                                               input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // Legal only when the wide word splits into at least two whole beats.
  function automatic bit unpack_params_ok(input int unsigned in_w,
                                          input int unsigned out_w);
    return (out_w != 0) && ((in_w % out_w) == 0) && ((in_w / out_w) >= 2);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry FIFO with wrapping pointers, shared by the pipe capture and
// unpack sides. o_ready is registered and held low during reset.
module pipe_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_ready
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         r_ready;

  logic         w_push;
  logic         w_pop;
  logic [1:0]   w_count_nxt;

  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign o_ready = r_ready;

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/pipe_unpack.sv
// Width-down converter: buffers IN_W-bit words and emits them as OUT_W-bit
// beats, least-significant beat first, with all outputs registered.
module pipe_unpack
  import pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned   RATIO     = unpack_ratio(IN_W, OUT_W);
  localparam int unsigned   BW        = $clog2(RATIO);
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  generate
    if (!unpack_params_ok(IN_W, OUT_W)) begin : g_bad_params
      $error("pipe_unpack: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
    end
  endgenerate

  ser_state_e      r_state;
  logic [IN_W-1:0] r_shift;
  logic [BW-1:0]   r_beat;
  logic            r_valid;
  logic            r_last;
  logic            r_busy;

  logic [IN_W-1:0] w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_buf_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_xfer;
  logic            w_at_last;
  logic [BW-1:0]   w_beat_inc;

  assign w_push     = in_valid && w_buf_ready;
  assign w_xfer     = (r_state == SHIFT) && out_ready;
  assign w_at_last  = (r_beat == LAST_BEAT);
  assign w_beat_inc = r_beat + 1'b1;

  // Pop on an idle load, or on the final-beat transfer so the next word
  // follows without a bubble.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || (w_xfer && w_at_last));

  pipe_skid_buf #(
    .W (IN_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_ready (w_buf_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_shift <= w_head;
            r_beat  <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (!w_at_last) begin
              r_shift <= r_shift >> OUT_W;
              r_beat  <= w_beat_inc;
              r_last  <= (w_beat_inc == LAST_BEAT);
            end else if (!w_empty) begin
              r_shift <= w_head;
              r_beat  <= '0;
              r_last  <= 1'b0;
            end else begin
              r_shift <= '0;
              r_beat  <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= !w_empty || (r_state == SHIFT);
    end
  end

  assign in_ready  = w_buf_ready;
  assign out_data  = r_shift[OUT_W-1:0];
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = r_busy;

  // Full is implied by in_ready; kept for readability of the buffer interface.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_pipe_unpack.sv
// Directed bench for pipe_unpack: default 4->2 instance plus an 8->2 instance.
module tb_pipe_unpack;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;

  logic [7:0] in_data2;
  logic       in_valid2;
  logic       in_ready2;
  logic [1:0] out_data2;
  logic       out_valid2;
  logic       out_ready2;
  logic       out_last2;
  logic       busy2;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [1:0] q_d  [$];
  logic       q_l  [$];
  int         q_c  [$];
  logic [1:0] q2_d [$];
  logic       q2_l [$];

  always #5 clk = ~clk;

  pipe_unpack #(.IN_W(4), .OUT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  pipe_unpack #(.IN_W(8), .OUT_W(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_last(out_last2), .busy(busy2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs settle at posedge+1, so a negedge sample predicts the next edge's transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_d.push_back(out_data);
      q_l.push_back(out_last);
      q_c.push_back(cyc);
    end
    if (!rst && out_valid2 && out_ready2) begin
      q2_d.push_back(out_data2);
      q2_l.push_back(out_last2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] d);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 20);
    chk("push_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic clear_q();
    q_d.delete(); q_l.delete(); q_c.delete();
    q2_d.delete(); q2_l.delete();
  endtask

  // Expected beat i lives at exp_d[2i+:2], its last flag at exp_l[i].
  task automatic check_beats(input string tag, input bit sel, input int n,
                             input logic [15:0] exp_d, input logic [7:0] exp_l,
                             input bit contiguous);
    int sz;
    logic [31:0] gd, gl;
    sz = sel ? q2_d.size() : q_d.size();
    chk({tag, "_count"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) begin
        gd = sel ? {30'd0, q2_d[i]} : {30'd0, q_d[i]};
        gl = sel ? {31'd0, q2_l[i]} : {31'd0, q_l[i]};
      end else begin
        gd = '1;
        gl = '1;
      end
      chk($sformatf("%s_data%0d", tag, i), gd, {30'd0, exp_d[2*i +: 2]});
      chk($sformatf("%s_last%0d", tag, i), gl, {31'd0, exp_l[i]});
      if (contiguous && i > 0 && i < sz)
        chk($sformatf("%s_gap%0d", tag, i), q_c[i] - q_c[i-1], 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;

    repeat (2) tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {30'd0, out_data}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single word with latency and busy tracking.
    out_ready = 1'b1;
    clear_q();
    push_word(4'hB);
    chk("single_lat0_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("single_b0_valid", {31'd0, out_valid}, 32'd1);
    chk("single_b0_data", {30'd0, out_data}, 32'd3);
    chk("single_b0_last", {31'd0, out_last}, 32'd0);
    chk("single_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("single_b1_data", {30'd0, out_data}, 32'd2);
    chk("single_b1_last", {31'd0, out_last}, 32'd1);
    tick();
    chk("single_done_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) tick();
    chk("single_busy_clear", {31'd0, busy}, 32'd0);

    // Back-to-back streaming.
    clear_q();
    push_word(4'h1);
    push_word(4'h2);
    push_word(4'h3);
    repeat (10) tick();
    check_beats("stream", 1'b0, 6, {4'b0, 2'b00, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01},
                8'b0010_1010, 1'b1);

    // Backpressure: three words held with out_ready low.
    out_ready = 1'b0;
    clear_q();
    push_word(4'h6);
    push_word(4'h9);
    push_word(4'hC);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_hold_data", {30'd0, out_data}, 32'd2);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    chk("bp_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    repeat (10) tick();
    check_beats("bp", 1'b0, 6, {4'b0, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10},
                8'b0010_1010, 1'b1);

    // Push refused on the edge a full buffer pops; accepted one cycle later.
    out_ready = 1'b0;
    clear_q();
    push_word(4'h7);
    push_word(4'h8);
    push_word(4'hD);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'h4;
    chk("full_rdy0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_rdy1", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_rdy_after_pop", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check_beats("full", 1'b0, 8,
                {2'b01, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11},
                8'b1010_1010, 1'b1);

    // Reset in the middle of a word.
    clear_q();
    push_word(4'hE);
    tick();
    tick();
    chk("mid_pre_data", {30'd0, out_data}, 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {30'd0, out_data}, 32'd0);
    chk("mid_rst_last", {31'd0, out_last}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    @(negedge clk) rst = 1'b0;
    tick();
    clear_q();
    push_word(4'h5);
    repeat (6) tick();
    check_beats("after_rst", 1'b0, 2, {12'b0, 2'b01, 2'b01}, 8'b0000_0010, 1'b1);

    // 8-to-2 instance.
    clear_q();
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    in_data2   = 8'hE4;
    begin
      logic acc;
      int   n;
      n = 0;
      do begin
        acc = in_ready2;
        tick();
        n++;
      end while (!acc && n < 20);
      chk("w8_push_accept", {31'd0, acc}, 32'd1);
    end
    in_valid2 = 1'b0;
    repeat (8) tick();
    check_beats("w8", 1'b1, 4, {8'b0, 2'b11, 2'b10, 2'b01, 2'b00}, 8'b0000_1000, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
